// File: rtl/lift_dispatcher.sv
// lift_dispatcher: assigns hall calls to the nearest idle car of NUM_LIFTS, each with its own travel/door FSM.
// Define LIFT_SEG_DISPLAY_EN to add a registered 7-segment display of the last assigned car number.
module lift_dispatcher #(
   parameter int NUM_LIFTS   = 2,
   parameter int FLOOR_W     = 4,
   parameter int NUM_FLOORS  = 16,
   parameter int MOVE_CYCLES = 4,
   parameter int DOOR_CYCLES = 8,
   localparam int ID_W = (NUM_LIFTS > 1) ? $clog2(NUM_LIFTS) : 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           call_valid,
   input  logic [FLOOR_W-1:0]             call_floor,
   output logic                           call_ready,
   output logic                           call_err,
   output logic                           assign_valid,
   output logic [ID_W-1:0]                assign_id,
   output logic [NUM_LIFTS*FLOOR_W-1:0]   lift_pos,
   output logic [NUM_LIFTS-1:0]           lift_up,
   output logic [NUM_LIFTS-1:0]           lift_down,
   output logic [NUM_LIFTS-1:0]           door_open
`ifdef LIFT_SEG_DISPLAY_EN
   ,
   output logic [6:0]                     seg_display
`endif
);
   localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

   state_t             state       [NUM_LIFTS];
   state_t             state_next  [NUM_LIFTS];
   logic [FLOOR_W-1:0] pos         [NUM_LIFTS];
   logic [FLOOR_W-1:0] pos_next    [NUM_LIFTS];
   logic [FLOOR_W-1:0] target      [NUM_LIFTS];
   logic [FLOOR_W-1:0] target_next [NUM_LIFTS];
   logic [CNT_W-1:0]   count       [NUM_LIFTS];
   logic [CNT_W-1:0]   count_next  [NUM_LIFTS];

   logic               found, merge, accept, bad, do_assign;
   logic [ID_W-1:0]    best_id;
   logic [FLOOR_W-1:0] best_dist;

   function automatic logic [FLOOR_W-1:0] distance(input logic [FLOOR_W-1:0] a, input logic [FLOOR_W-1:0] b);
      return (a > b) ? a - b : b - a;
   endfunction

   // Scan cars: readiness, merge against busy targets, nearest idle car (strict < keeps lowest index on ties).
   always_comb begin
      call_ready = 1'b0;
      merge      = 1'b0;
      found      = 1'b0;
      best_id    = '0;
      best_dist  = '0;
      for (int i = 0; i < NUM_LIFTS; i++) begin
         if (state[i] == IDLE) begin
            call_ready = 1'b1;
            if (!found || distance(call_floor, pos[i]) < best_dist) begin
               found     = 1'b1;
               best_id   = ID_W'(i);
               best_dist = distance(call_floor, pos[i]);
            end
         end else if (target[i] == call_floor) begin
            merge = 1'b1;
         end
      end
   end

   assign accept    = call_valid && call_ready;
   assign bad       = int'(call_floor) >= NUM_FLOORS;
   assign do_assign = accept && !bad && !merge;

   always_comb begin
      for (int i = 0; i < NUM_LIFTS; i++) begin
         state_next[i]  = state[i];
         pos_next[i]    = pos[i];
         target_next[i] = target[i];
         count_next[i]  = count[i];
         case (state[i])
            IDLE: if (do_assign && best_id == ID_W'(i)) begin
               target_next[i] = call_floor;
               count_next[i]  = '0;
               state_next[i]  = (call_floor == pos[i]) ? DOOR : MOVE;
            end
            MOVE: if (count[i] == CNT_W'(MOVE_CYCLES - 1)) begin
               count_next[i] = '0;
               pos_next[i]   = (target[i] > pos[i]) ? pos[i] + 1'b1 : pos[i] - 1'b1;
               state_next[i] = (pos_next[i] == target[i]) ? DOOR : MOVE;
            end else begin
               count_next[i] = count[i] + 1'b1;
            end
            DOOR: if (count[i] == CNT_W'(DOOR_CYCLES - 1)) begin
               count_next[i] = '0;
               state_next[i] = IDLE;
            end else begin
               count_next[i] = count[i] + 1'b1;
            end
            default: state_next[i] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_LIFTS; i++) begin
            state[i]  <= IDLE;
            pos[i]    <= '0;
            target[i] <= '0;
            count[i]  <= '0;
         end
         assign_valid <= 1'b0;
         assign_id    <= '0;
         call_err     <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_LIFTS; i++) begin
            state[i]  <= state_next[i];
            pos[i]    <= pos_next[i];
            target[i] <= target_next[i];
            count[i]  <= count_next[i];
         end
         assign_valid <= do_assign;
         call_err     <= accept && bad;
         if (do_assign) assign_id <= best_id;
      end
   end

   for (genvar g = 0; g < NUM_LIFTS; g++) begin : g_car
      assign lift_pos[g*FLOOR_W +: FLOOR_W] = pos[g];
      assign lift_up[g]   = (state[g] == MOVE) && (target[g] > pos[g]);
      assign lift_down[g] = (state[g] == MOVE) && (target[g] < pos[g]);
      assign door_open[g] = (state[g] == DOOR);
   end

`ifdef LIFT_SEG_DISPLAY_EN
   // Shows car number (assign_id + 1), active-high segments a..g.
   function automatic logic [6:0] seg_code(input logic [ID_W-1:0] id);
      case (int'(id))
         0:       return 7'b0110000;
         1:       return 7'b1101101;
         2:       return 7'b1111001;
         3:       return 7'b0110011;
         4:       return 7'b1011011;
         5:       return 7'b1011111;
         6:       return 7'b1110000;
         default: return 7'b1111111;
      endcase
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) seg_display <= 7'b0000000;
      else if (do_assign) seg_display <= seg_code(best_id);
   end
`endif
endmodule

// File: tb/tb_lift_dispatcher.sv
// tb_lift_dispatcher: directed checks of dispatch, travel timing, merge, error, back-pressure and async reset.
module tb_lift_dispatcher;
   localparam int FW = 5;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          call_valid = 1'b0;
   logic [FW-1:0] call_floor = '0;
   logic          call_ready, call_err, assign_valid;
   logic [0:0]    assign_id;
   logic [2*FW-1:0] lift_pos;
   logic [1:0]    lift_up, lift_down, door_open;
`ifdef LIFT_SEG_DISPLAY_EN
   logic [6:0]    seg_display;
`endif
   int compared = 0;
   int mismatched = 0;

   lift_dispatcher #(
      .NUM_LIFTS(2), .FLOOR_W(FW), .NUM_FLOORS(16), .MOVE_CYCLES(4), .DOOR_CYCLES(8)
   ) dut (
      .clock(clock), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
      .call_ready(call_ready), .call_err(call_err), .assign_valid(assign_valid),
      .assign_id(assign_id), .lift_pos(lift_pos), .lift_up(lift_up),
      .lift_down(lift_down), .door_open(door_open)
`ifdef LIFT_SEG_DISPLAY_EN
      , .seg_display(seg_display)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clock);
   endtask

   task automatic call(input logic [FW-1:0] f);
      call_valid = 1'b1;
      call_floor = f;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((lift_up | lift_down | door_open) != 2'b00 && n < budget) begin
         tick();
         n++;
      end
      check("idle_within_budget", {30'd0, lift_up | lift_down | door_open}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tick();
      check("rst_ready", call_ready, 1);
      check("rst_assign_valid", assign_valid, 0);
      check("rst_assign_id", assign_id, 0);
      check("rst_call_err", call_err, 0);
      check("rst_pos", lift_pos, 0);
      check("rst_moving", {lift_up, lift_down, door_open}, 0);
`ifdef LIFT_SEG_DISPLAY_EN
      check("rst_seg", seg_display, 7'b0000000);
`endif
      reset = 1'b0;

      // Call floor 5 from reset: car0 travels 20 cycles then opens door for 8
      call(5);
      tick();
      call_valid = 1'b0;
      check("a_valid", assign_valid, 1);
      check("a_id", assign_id, 0);
      check("a_up", lift_up, 2'b01);
      check("a_pos0", lift_pos[FW-1:0], 0);
`ifdef LIFT_SEG_DISPLAY_EN
      check("a_seg", seg_display, 7'b0110000);
`endif
      tick();
      check("a_pulse_end", assign_valid, 0);
      tick(18);
      check("a_up_last", lift_up, 2'b01);
      check("a_pos_last", lift_pos[FW-1:0], 4);
      tick();
      check("a_door", door_open, 2'b01);
      check("a_up_clear", lift_up, 2'b00);
      check("a_pos_arrive", lift_pos[FW-1:0], 5);
      tick(7);
      check("a_door_last", door_open, 2'b01);
      tick();
      check("a_door_closed", door_open, 2'b00);

      // Car0 at 5, car1 at 0: floor 12 goes to car0; repeat merges; floor 20 errors
      call(12);
      tick();
      check("b_valid", assign_valid, 1);
      check("b_id", assign_id, 0);
      check("b_up", lift_up, 2'b01);
      call(12);
      tick();
      check("b_merge_no_assign", assign_valid, 0);
      check("b_merge_car1_still", lift_up | lift_down | door_open, 2'b01);
      call(20);
      tick();
      call_valid = 1'b0;
      check("b_err", call_err, 1);
      check("b_err_no_assign", assign_valid, 0);
      check("b_err_car1_pos", lift_pos[2*FW-1:FW], 0);
      tick();
      check("b_err_pulse_end", call_err, 0);
      tick(4);
      check("b_pos_mid_move", lift_pos[FW-1:0], 6);
      reset = 1'b1;
      #1;
      check("b_rst_pos", lift_pos, 0);
      check("b_rst_up", lift_up, 0);
      check("b_rst_id", assign_id, 0);
`ifdef LIFT_SEG_DISPLAY_EN
      check("b_rst_seg", seg_display, 7'b0000000);
`endif
      tick();
      reset = 1'b0;
      check("b_ready_after_rst", call_ready, 1);

      // Call floor 0 with car0 at 0: door straight away, no motion
      call(0);
      tick();
      call_valid = 1'b0;
      check("c_valid", assign_valid, 1);
      check("c_door", door_open, 2'b01);
      check("c_no_move", {lift_up, lift_down}, 0);
      tick(7);
      check("c_door_last", door_open, 2'b01);
      tick();
      check("c_door_closed", door_open, 2'b00);

      // Both cars busy: held call waits for first car to go idle
      call(3);
      tick();
      check("d_id0", assign_id, 0);
      check("d_up0", lift_up, 2'b01);
      call(9);
      tick();
      check("d_id1", assign_id, 1);
      check("d_up_both", lift_up, 2'b11);
      check("d_not_ready", call_ready, 0);
`ifdef LIFT_SEG_DISPLAY_EN
      check("d_seg", seg_display, 7'b1101101);
`endif
      call(7);
      tick(18);
      check("d_still_busy", call_ready, 0);
      check("d_door0", door_open, 2'b01);
      check("d_no_assign_while_busy", assign_valid, 0);
      tick();
      check("d_ready_rise", call_ready, 1);
      check("d_door0_closed", door_open, 2'b00);
      tick();
      call_valid = 1'b0;
      check("d_held_valid", assign_valid, 1);
      check("d_held_id", assign_id, 0);
      check("d_held_up", lift_up, 2'b11);
      wait_idle(100);
      check("d_parked", lift_pos, {5'd9, 5'd7});

      // Nearest: floor 10 -> car1; then floor 4 -> car0 moving down
      call(10);
      tick();
      check("e_id1", assign_id, 1);
      check("e_up1", lift_up, 2'b10);
      call(4);
      tick();
      call_valid = 1'b0;
      check("e_valid", assign_valid, 1);
      check("e_id0", assign_id, 0);
      check("e_down0", lift_down, 2'b01);
      wait_idle(100);
      check("e_parked", lift_pos, {5'd10, 5'd4});

      // Tie at distance 3 goes to car0
      call(7);
      tick();
      call_valid = 1'b0;
      check("f_tie_id", assign_id, 0);
      check("f_tie_up", lift_up, 2'b01);
      wait_idle(100);
      check("f_parked", lift_pos[FW-1:0], 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
